// File: rtl/present_key_sched_if.sv
// present_key_sched_if: start/key request and round-key stream bundle for present_key_sched
interface present_key_sched_if #(
  parameter int KEY_W = 128,
  parameter int ROUNDS = 31
);
  localparam int RW = $clog2(ROUNDS + 2);
  logic start;
  logic dec;
  logic [KEY_W-1:0] key;
  logic [63:0] rkey;
  logic rkey_valid;
  logic rkey_ready;
  logic [RW-1:0] round;
  logic busy;
  logic done;
  logic [KEY_W-1:0] final_key;
  modport master (
    output start, dec, key, rkey_ready,
    input rkey, rkey_valid, round, busy, done, final_key
  );
  modport slave (
    input start, dec, key, rkey_ready,
    output rkey, rkey_valid, round, busy, done, final_key
  );
endinterface

// File: rtl/present_key_sched.sv
// present_key_sched: PRESENT 80/128-bit round-key generator, valid/ready key stream; PRESENT_KS_INV_EN adds inverse mode
module present_key_sched #(
  parameter int KEY_W = 128,
  parameter int ROUNDS = 31
) (
  input logic clk,
  input logic rst,
  present_key_sched_if.slave ks
);
  // round must reach ROUNDS+1, so it is one bit wider than the 5-bit counter field
  localparam int RW = $clog2(ROUNDS + 2);
  localparam int FB = (KEY_W == 80) ? 15 : 62;
  localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  generate
    if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
      $error("present_key_sched: KEY_W must be 80 or 128");
    end
  endgenerate
  function automatic logic [3:0] sb(input logic [3:0] n);
    return SBOX[{n, 2'b00} +: 4];
  endfunction
  function automatic logic [KEY_W-1:0] fwd_step(input logic [KEY_W-1:0] k, input logic [RW-1:0] i);
    logic [KEY_W-1:0] r;
    r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    r[KEY_W-1 -: 4] = sb(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) r[KEY_W-5 -: 4] = sb(r[KEY_W-5 -: 4]);
    r[FB +: 5] = r[FB +: 5] ^ 5'(i);
    return r;
  endfunction
`ifdef PRESENT_KS_INV_EN
  localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;
  function automatic logic [3:0] sbi(input logic [3:0] n);
    return SBOX_INV[{n, 2'b00} +: 4];
  endfunction
  // undoes the forward step that produced round i from round i-1
  function automatic logic [KEY_W-1:0] inv_step(input logic [KEY_W-1:0] k, input logic [RW-1:0] i);
    logic [KEY_W-1:0] r;
    logic [RW-1:0] j;
    j = i - RW'(1);
    r = k;
    r[FB +: 5] = r[FB +: 5] ^ 5'(j);
    r[KEY_W-1 -: 4] = sbi(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) r[KEY_W-5 -: 4] = sbi(r[KEY_W-5 -: 4]);
    return {r[60:0], r[KEY_W-1:61]};
  endfunction
`endif
  logic [0:0] state_q, state_d;
  logic dir_q, dir_d, done_q, done_d, dec_w, xfer, last;
  logic [KEY_W-1:0] kreg_q, kreg_d, fin_q, fin_d, step;
  logic [RW-1:0] round_q, round_d;
  always_comb begin
`ifdef PRESENT_KS_INV_EN
    dec_w = ks.dec;
    step = dir_q ? inv_step(kreg_q, round_q) : fwd_step(kreg_q, round_q);
`else
    dec_w = 1'b0;
    step = fwd_step(kreg_q, round_q);
`endif
    xfer = (state_q == RUN) & ks.rkey_ready;
    last = dir_q ? (round_q == RW'(1)) : (round_q == RW'(ROUNDS + 1));
    state_d = state_q;
    dir_d = dir_q;
    kreg_d = kreg_q;
    round_d = round_q;
    fin_d = fin_q;
    done_d = 1'b0;
    if (state_q == IDLE && ks.start) begin
      state_d = RUN;
      dir_d = dec_w;
      kreg_d = ks.key;
      round_d = dec_w ? RW'(ROUNDS + 1) : RW'(1);
    end else if (xfer && last) begin
      state_d = IDLE;
      done_d = 1'b1;
      fin_d = dir_q ? fin_q : kreg_q;
    end else if (xfer) begin
      kreg_d = step;
      round_d = dir_q ? round_q - RW'(1) : round_q + RW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q <= 1'b0;
      kreg_q <= '0;
      round_q <= '0;
      fin_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      kreg_q <= kreg_d;
      round_q <= round_d;
      fin_q <= fin_d;
      done_q <= done_d;
    end
  end
  assign ks.rkey = kreg_q[KEY_W-1 -: 64];
  assign ks.rkey_valid = state_q == RUN;
  assign ks.busy = state_q == RUN;
  assign ks.round = round_q;
  assign ks.done = done_q;
  assign ks.final_key = fin_q;
endmodule
